fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit FIFO wrapper. Pops bytes from the FIFO read side (data, empty flag, read enable) and serialises each as an asynchronous frame on TX: one start bit, WIDTH data bits LSB-first, then STOP_BITS stop bits. Bit timing comes from an internal clock divider. Frames can be sent back-to-back with no idle gap between them.

Parameters:
WIDTH, 8, data bits per frame; must match the FIFO data width.
CLKS_PER_BIT, 16, CLK cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  reset, synchronous and active-high.
FIFO_DATA  input  WIDTH  FIFO head data (show-ahead); valid whenever FIFO_EMPTY=0.
FIFO_EMPTY  input  1  FIFO empty flag.
FIFO_RD_EN  output  WIDTH? no, 1  single-cycle pop strobe to the FIFO.
EN  input  1  transmit enable; gates the start of new frames only.
TX  output  1  serial line; idles high.
BUSY  output  1  high while a frame is in progress (states START, DATA, STOP).
FRAME_DONE  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (RST=1 at a clock edge):
  - Next cycle: state=IDLE, TX=1, BUSY=0, FRAME_DONE=0, counters cleared.
  - FIFO_RD_EN is forced to 0 while RST=1.
  - A frame in progress is aborted; the shift-register byte is discarded.
- FSM states: IDLE, START, DATA, STOP.
- Pop condition, "pop" = EN & ~FIFO_EMPTY & ~RST & (state==IDLE | last cycle of final stop bit).
  - FIFO_RD_EN = pop, combinational.
  - On pop, FIFO_DATA is captured into the shift register on the same edge and the next state is START.
  - FIFO_RD_EN is never asserted while FIFO_EMPTY=1, and is high for at most one cycle per frame.
- Latency: TX falls (start bit) on the cycle after the pop cycle. TX is registered.
- START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: TX=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - Bit index counts 0..WIDTH-1; after bit WIDTH-1, go to STOP.
- STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - FRAME_DONE=1 in the final cycle only.
  - In that final cycle: if pop, next state is START (back-to-back, no gap); otherwise IDLE.
- Frame length is exactly (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- Counters:
  - Bit timer width = $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index width = $clog2(WIDTH)+1.
  - Stop counter counts STOP_BITS bit periods.
- BUSY = (state != IDLE), registered with the state.
- EN falling mid-frame: the current frame completes unchanged and no further pop occurs.
- EN rising while IDLE with FIFO non-empty: pop in that same cycle.
- FIFO becomes empty exactly at the end of a frame: go to IDLE with TX=1; the next pop occurs as soon as FIFO_EMPTY=0.
- FIFO_DATA changing while a frame is in progress has no effect.

Decomposition:
- Package fifo_uart_tx_pkg holds:
  - state enum: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - TX_IDLE=1'b1
  - START_BIT=1'b0
- Sub-module uart_bit_timer (parameter CLKS_PER_BIT):
  - Inputs: CLK, RST, clear.
  - Output: bit_end pulse on the last cycle of each bit period.
  - Cleared on pop and on reset.
- The FSM, shift register and bit/stop counters stay in fifo_uart_tx.

Test Plan:
All cases use CLKS_PER_BIT=4, WIDTH=8, STOP_BITS=1 unless stated otherwise.
1. FIFO holds 0xA5, EN=1.
   - FIFO_RD_EN=1 for exactly one cycle.
   - TX per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
   - BUSY high for 40 cycles; FRAME_DONE pulses on cycle 40.
2. FIFO holds 0x00 then 0xFF.
   - Second pop coincides with the first FRAME_DONE.
   - The start bit of 0xFF immediately follows the first stop bit: 80 contiguous BUSY cycles.
3. FIFO empty, EN=1 for 100 cycles: FIFO_RD_EN never asserts, TX=1, BUSY=0.
4. Send 0x3C, drop EN at cycle 10 while two more bytes are queued.
   - The 0x3C frame completes (40 cycles).
   - No further pop occurs; TX stays at 1 until EN=1 again, then the next byte pops.
5. RST=1 for one cycle at cycle 20 of a frame.
   - Next cycle: TX=1, BUSY=0, FRAME_DONE never pulses.
   - After release, the next queued byte transmits a clean 40-cycle frame.
6. STOP_BITS=2, send 0x81: stop high for 8 cycles, 44-cycle frame, FRAME_DONE on cycle 44.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and line levels for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Show-ahead FIFO read side: the FIFO (master) presents head data and empty, the drain (slave) pops.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] FIFO_DATA;
  logic             FIFO_EMPTY;
  logic             FIFO_RD_EN;

  modport master (output FIFO_DATA, output FIFO_EMPTY, input FIFO_RD_EN);
  modport slave  (input FIFO_DATA, input FIFO_EMPTY, output FIFO_RD_EN);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Serial bit-period divider: bit_end marks the last CLK cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends each as start + LSB-first data + stop bits on TX.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  fifo_uart_tx_if.slave        fifo,
  input  logic                 EN,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 FRAME_DONE
);
  localparam int IW = $clog2(WIDTH) + 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic [1:0]       stop_cnt, stop_cnt_n;
  logic             bit_end, last_stop, pop, tx_n;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (pop),
    .bit_end(bit_end)
  );

  assign last_stop       = (state == STOP) && bit_end && (stop_cnt == 2'(STOP_BITS - 1));
  assign pop             = EN && !fifo.FIFO_EMPTY && !RST && ((state == IDLE) || last_stop);
  assign fifo.FIFO_RD_EN = pop;
  assign FRAME_DONE      = last_stop && !RST;
  assign BUSY            = (state != IDLE);

  // A pop can only happen in IDLE or the final stop cycle, so it takes priority over the state walk.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    if (pop) begin
      state_n = START;
      shift_n = fifo.FIFO_DATA;
    end else begin
      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_n = shift >> 1;
            if (bit_idx == IW'(WIDTH - 1)) begin
              state_n    = STOP;
              stop_cnt_n = '0;
            end else begin
              bit_idx_n = bit_idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (last_stop) begin
            state_n = IDLE;
          end else if (bit_end) begin
            stop_cnt_n = stop_cnt + 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // TX is registered from the next-state view so the start bit appears the cycle after the pop.
    case (state_n)
      START:   tx_n = START_BIT;
      DATA:    tx_n = shift_n[0];
      default: tx_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      TX       <= TX_IDLE;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      TX       <= tx_n;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, per-DUT monitors decode TX frames on FRAME_DONE.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int W   = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance 0 uses one stop bit, instance 1 uses two.
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int SB   = g + 1;
    localparam int FLEN = (1 + W + SB) * CPB;

    fifo_uart_tx_if #(.WIDTH(W)) fif ();
    logic           tx, busy, done;
    logic [W-1:0]   q[$];
    logic [W-1:0]   expq[$];
    logic           rd_seen = 1'b0;
    int             pops = 0, dones = 0, coinc = 0, run = 0, last_run = 0, k = 0;
    logic [W+SB:0]  frame = '0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .fifo      (fif),
      .EN        (g == 0 ? en0 : en1),
      .TX        (tx),
      .BUSY      (busy),
      .FRAME_DONE(done)
    );

    always @(posedge CLK) begin
      #2;
      if (rd_seen && q.size() > 0) void'(q.pop_front());
      fif.FIFO_EMPTY = (q.size() == 0);
      fif.FIFO_DATA  = (q.size() > 0) ? q[0] : '0;
    end

    always @(negedge CLK) begin
      logic [W-1:0] e;
      if (fif.FIFO_RD_EN) begin
        pops++;
        chk("rd_en_when_empty", 32'(fif.FIFO_EMPTY), 32'd0);
        chk("rd_en_one_cycle", 32'(rd_seen), 32'd0);
        if (done) coinc++;
      end
      rd_seen = fif.FIFO_RD_EN;
      if (busy) begin
        k++;
        run++;
        if (k <= FLEN && (k - 1) % CPB == CPB / 2) frame[(k - 1) / CPB] = tx;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        k = 0;
      end
      if (done) begin
        dones++;
        chk("frame_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("frame_len", 32'(k), 32'(FLEN));
          chk("frame_bits", 32'(frame), 32'({{SB{1'b1}}, e, 1'b0}));
        end
        k = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push0(input logic [W-1:0] b);
    u[0].q.push_back(b);
    u[0].expq.push_back(b);
  endtask

  task automatic push1(input logic [W-1:0] b);
    u[1].q.push_back(b);
    u[1].expq.push_back(b);
  endtask

  task automatic drain0(input string name);
    int n = 0;
    while ((u[0].expq.size() != 0 || u[0].busy) && n < 400) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
    tick(1);
  endtask

  task automatic drain1(input string name);
    int n = 0;
    while ((u[1].expq.size() != 0 || u[1].busy) && n < 400) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
    tick(1);
  endtask

  initial begin
    int p0, d0, c0, bad, n;
    RST = 1'b1;
    tick(3);
    chk("rst_tx", 32'(u[0].tx), 32'd1);
    chk("rst_busy", 32'(u[0].busy), 32'd0);
    chk("rst_done", 32'(u[0].done), 32'd0);

    // 0xA5 single frame; pop must be held off while reset is high
    en0 = 1'b1;
    push0(8'hA5);
    tick(1);
    chk("rst_blocks_pop", 32'(u[0].fif.FIFO_RD_EN), 32'd0);
    p0 = u[0].pops;
    d0 = u[0].dones;
    RST = 1'b0;
    tick(1);
    chk("t1_start_tx", 32'(u[0].tx), 32'd0);
    chk("t1_start_busy", 32'(u[0].busy), 32'd1);
    drain0("t1_drain");
    chk("t1_pops", 32'(u[0].pops - p0), 32'd1);
    chk("t1_busy_run", 32'(u[0].last_run), 32'd40);
    chk("t1_dones", 32'(u[0].dones - d0), 32'd1);

    // back-to-back 0x00, 0xFF
    p0 = u[0].pops;
    d0 = u[0].dones;
    c0 = u[0].coinc;
    push0(8'h00);
    push0(8'hFF);
    drain0("t2_drain");
    chk("t2_pops", 32'(u[0].pops - p0), 32'd2);
    chk("t2_pop_at_done", 32'(u[0].coinc - c0), 32'd1);
    chk("t2_busy_run", 32'(u[0].last_run), 32'd80);
    chk("t2_dones", 32'(u[0].dones - d0), 32'd2);

    // empty FIFO with EN high
    p0 = u[0].pops;
    bad = 0;
    repeat (100) begin
      tick(1);
      if (u[0].tx !== 1'b1 || u[0].busy !== 1'b0) bad++;
    end
    chk("t3_pops", 32'(u[0].pops - p0), 32'd0);
    chk("t3_idle", 32'(bad), 32'd0);

    // EN dropped mid-frame with bytes still queued
    p0 = u[0].pops;
    push0(8'h3C);
    push0(8'h11);
    push0(8'h22);
    n = 0;
    while (!u[0].busy && n < 10) begin
      tick(1);
      n++;
    end
    chk("t4_started", 32'(u[0].busy), 32'd1);
    tick(9);
    en0 = 1'b0;
    n = 0;
    while (u[0].busy && n < 100) begin
      tick(1);
      n++;
    end
    chk("t4_ended", 32'(u[0].busy), 32'd0);
    tick(1);
    chk("t4_busy_run", 32'(u[0].last_run), 32'd40);
    chk("t4_pops", 32'(u[0].pops - p0), 32'd1);
    chk("t4_queued", 32'(u[0].expq.size()), 32'd2);
    bad = 0;
    repeat (50) begin
      tick(1);
      if (u[0].tx !== 1'b1 || u[0].busy !== 1'b0) bad++;
    end
    chk("t4_hold_idle", 32'(bad), 32'd0);
    chk("t4_hold_pops", 32'(u[0].pops - p0), 32'd1);
    en0 = 1'b1;
    #1;
    chk("t4_pop_on_en", 32'(u[0].fif.FIFO_RD_EN), 32'd1);
    drain0("t4_drain");
    chk("t4_pops_all", 32'(u[0].pops - p0), 32'd3);

    // reset at cycle 20 of a frame
    p0 = u[0].pops;
    d0 = u[0].dones;
    push0(8'h5A);
    push0(8'h66);
    n = 0;
    while (!u[0].busy && n < 10) begin
      tick(1);
      n++;
    end
    chk("t5_started", 32'(u[0].busy), 32'd1);
    tick(19);
    RST = 1'b1;
    void'(u[0].expq.pop_front());
    tick(1);
    RST = 1'b0;
    chk("t5_tx", 32'(u[0].tx), 32'd1);
    chk("t5_busy", 32'(u[0].busy), 32'd0);
    chk("t5_done", 32'(u[0].done), 32'd0);
    drain0("t5_drain");
    chk("t5_dones", 32'(u[0].dones - d0), 32'd1);
    chk("t5_busy_run", 32'(u[0].last_run), 32'd40);
    chk("t5_pops", 32'(u[0].pops - p0), 32'd2);

    // two stop bits, 0x81
    p0 = u[1].pops;
    d0 = u[1].dones;
    en1 = 1'b1;
    push1(8'h81);
    drain1("t6_drain");
    chk("t6_busy_run", 32'(u[1].last_run), 32'd44);
    chk("t6_dones", 32'(u[1].dones - d0), 32'd1);
    chk("t6_pops", 32'(u[1].pops - p0), 32'd1);

    chk("scoreboard_empty", 32'(u[0].expq.size() + u[1].expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
